// File: rtl/kbd_music_ctrl_gen.sv
// Keyboard-to-player control: turns ASCII key presses into direction, pause,
// restart and playback-rate controls, executing each press once on a music tick.
module kbd_music_ctrl_gen #(
  parameter int unsigned        SPEED_W       = 8,
  parameter logic [SPEED_W-1:0] SPEED_DEFAULT = 8'd64,
  parameter logic [SPEED_W-1:0] SPEED_MIN     = 8'd16,
  parameter logic [SPEED_W-1:0] SPEED_MAX     = 8'd192,
  parameter logic [SPEED_W-1:0] SPEED_STEP    = 8'd8,
  parameter int unsigned        RESTART_TICKS = 2,
  parameter bit                 CASE_FOLD     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [7:0]         kbd_received_ascii_code,
  input  logic               update_code,
  output logic               increment,
  output logic               pause,
  output logic               restart,
  output logic [SPEED_W-1:0] speed_div,
  output logic               cmd_done
);

  localparam int unsigned CNT_W = (RESTART_TICKS > 1) ? $clog2(RESTART_TICKS) : 1;
  localparam int unsigned EXT_W = SPEED_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_TICKS - 1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_RST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         pend_code_q, pend_code_d;
  logic               pend_valid_q, pend_valid_d;
  logic               increment_q, increment_d;
  logic               pause_q, pause_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               cmd_done_q, cmd_done_d;

  logic [7:0]         code_fold_c;
  logic [7:0]         cmd_code_c;
  logic               cmd_valid_c;
  logic               restart_go_c;
  logic [EXT_W-1:0]   spd_ext_c, spd_sum_c, spd_floor_c;
  logic [SPEED_W-1:0] spd_faster_c, spd_slower_c;

  // Optional lowercase-to-uppercase folding of the incoming key code
  always_comb begin
    code_fold_c = kbd_received_ascii_code;
    if (CASE_FOLD && (kbd_received_ascii_code >= 8'h61) && (kbd_received_ascii_code <= 8'h7A)) begin
      code_fold_c = kbd_received_ascii_code - 8'h20;
    end
  end

  // Command candidate: a key arriving on the tick bypasses the pending register
  always_comb begin
    cmd_valid_c = tick & (update_code | pend_valid_q);
    cmd_code_c  = update_code ? code_fold_c : pend_code_q;
  end

  // Saturating tempo arithmetic in one extra bit so nothing wraps
  always_comb begin
    spd_ext_c    = {1'b0, speed_q};
    spd_sum_c    = spd_ext_c + EXT_W'(SPEED_STEP);
    spd_floor_c  = EXT_W'(SPEED_STEP) + EXT_W'(SPEED_MIN);
    spd_faster_c = (spd_ext_c < spd_floor_c) ? SPEED_MIN : (speed_q - SPEED_STEP);
    spd_slower_c = (spd_sum_c > EXT_W'(SPEED_MAX)) ? SPEED_MAX : spd_sum_c[SPEED_W-1:0];
  end

  // Next-state: pending capture, key decode and restart FSM
  always_comb begin
    pend_code_d  = pend_code_q;
    pend_valid_d = pend_valid_q;
    increment_d  = increment_q;
    pause_d      = pause_q;
    speed_d      = speed_q;
    cmd_done_d   = 1'b0;
    restart_go_c = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (tick) begin
      pend_valid_d = 1'b0;
    end else if (update_code) begin
      pend_valid_d = 1'b1;
      pend_code_d  = code_fold_c;
    end

    if (cmd_valid_c) begin
      cmd_done_d = 1'b1;
      case (cmd_code_c)
        8'h45:   pause_d      = 1'b0;
        8'h44:   pause_d      = 1'b1;
        8'h46:   increment_d  = 1'b1;
        8'h42:   increment_d  = 1'b0;
        8'h52:   restart_go_c = 1'b1;
        8'h55:   speed_d      = spd_faster_c;
        8'h4C:   speed_d      = spd_slower_c;
        8'h4E:   speed_d      = SPEED_DEFAULT;
        default: cmd_done_d   = 1'b0;
      endcase
    end

    case (state_q)
      ST_RUN: begin
        if (restart_go_c) begin
          state_d = ST_RST;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_RST: begin
        if (restart_go_c) begin
          cnt_d = CNT_LOAD;
        end else if (tick) begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      pend_code_q  <= '0;
      pend_valid_q <= 1'b0;
      increment_q  <= 1'b1;
      pause_q      <= 1'b1;
      speed_q      <= SPEED_DEFAULT;
      cmd_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_code_q  <= pend_code_d;
      pend_valid_q <= pend_valid_d;
      increment_q  <= increment_d;
      pause_q      <= pause_d;
      speed_q      <= speed_d;
      cmd_done_q   <= cmd_done_d;
    end
  end

  assign increment = increment_q;
  assign pause     = pause_q;
  assign restart   = (state_q == ST_RST);
  assign speed_div = speed_q;
  assign cmd_done  = cmd_done_q;

endmodule

// File: tb/tb_kbd_music_ctrl_gen.sv
// Scoreboard bench for kbd_music_ctrl_gen: a folding and a non-folding instance.
module tb_kbd_music_ctrl_gen;

  typedef struct packed {
    logic       inc;
    logic       pau;
    logic       rst;
    logic [7:0] spd;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, tick, upd, upd_nf;
  logic [7:0] code;
  logic       m_inc, m_pau, m_rst, m_done;
  logic       n_inc, n_pau, n_rst, n_done;
  logic [7:0] m_spd, n_spd;

  exp_t q_m[$];
  exp_t q_n[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   nf_en = 1'b0;
  bit   started = 1'b0;
  logic smp_m, smp_n;

  always #5 clk = ~clk;

  kbd_music_ctrl_gen dut (
    .clk(clk), .reset(rst_n), .tick(tick), .kbd_received_ascii_code(code),
    .update_code(upd), .increment(m_inc), .pause(m_pau), .restart(m_rst),
    .speed_div(m_spd), .cmd_done(m_done)
  );

  kbd_music_ctrl_gen #(.CASE_FOLD(1'b0)) dut_nf (
    .clk(clk), .reset(rst_n), .tick(tick), .kbd_received_ascii_code(code),
    .update_code(upd_nf), .increment(n_inc), .pause(n_pau), .restart(n_rst),
    .speed_div(n_spd), .cmd_done(n_done)
  );

  function automatic exp_t mk(input logic i, input logic p, input logic r,
                              input logic [7:0] s, input logic d);
    mk = '{inc: i, pau: p, rst: r, spd: s, done: d};
  endfunction

  task automatic chk(input string nm, input exp_t got, input exp_t e);
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got inc=%0b pause=%0b restart=%0b speed=%0d done=%0b, exp inc=%0b pause=%0b restart=%0b speed=%0d done=%0b",
               nm, $time, got.inc, got.pau, got.rst, got.spd, got.done,
               e.inc, e.pau, e.rst, e.spd, e.done);
    end
  endtask

  task automatic chk_idle(input string nm, input logic got);
    n_chk++;
    if (got !== 1'b0) begin
      n_fail++;
      $display("FAIL %s @%0t: cmd_done=%0b outside a tick response, exp 0", nm, $time, got);
    end
  endtask

  // Mark the cycles whose outputs the scoreboards must check
  always @(posedge clk) begin
    smp_m <= tick | !rst_n;
    smp_n <= (tick & nf_en) | !rst_n;
  end

  // Monitor for the folding instance
  always @(negedge clk) begin
    exp_t e;
    if (smp_m === 1'b1) begin
      if (q_m.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL main_underflow @%0t: output sampled, exp queue empty", $time);
      end else begin
        e = q_m.pop_front();
        chk("main", mk(m_inc, m_pau, m_rst, m_spd, m_done), e);
      end
    end else if (started) begin
      chk_idle("main_idle", m_done);
    end
  end

  // Monitor for the non-folding instance
  always @(negedge clk) begin
    exp_t e;
    if (smp_n === 1'b1) begin
      if (q_n.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL nf_underflow @%0t: output sampled, exp queue empty", $time);
      end else begin
        e = q_n.pop_front();
        chk("nofold", mk(n_inc, n_pau, n_rst, n_spd, n_done), e);
      end
    end else if (started) begin
      chk_idle("nofold_idle", n_done);
    end
  end

  task automatic press(input logic [7:0] c);
    code = c; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic press_nf(input logic [7:0] c);
    code = c; upd_nf = 1'b1;
    @(negedge clk);
    upd_nf = 1'b0;
  endtask

  task automatic tk(input exp_t em);
    q_m.push_back(em);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tk2(input exp_t em, input exp_t en);
    q_m.push_back(em);
    q_n.push_back(en);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press_tick(input logic [7:0] c, input exp_t em);
    q_m.push_back(em);
    code = c; upd = 1'b1; tick = 1'b1;
    @(negedge clk);
    upd = 1'b0; tick = 1'b0;
  endtask

  // Reset cycle with a tick deliberately coincident to show reset dominates
  task automatic do_reset();
    q_m.push_back(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    q_n.push_back(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    rst_n = 1'b0; tick = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b0;
  endtask

  logic [7:0] exp_u [10];
  logic [7:0] s_exp;

  initial begin
    exp_u = '{8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16};
    rst_n = 1'b0; tick = 1'b0; upd = 1'b0; upd_nf = 1'b0; code = 8'h00;
    q_m.push_back(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    q_n.push_back(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    started = 1'b1;

    // 1: 'E' then tick three clocks later
    press(8'h45);
    repeat (2) @(negedge clk);
    tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b1));

    // 2: two 'R' presses, restart high for two ticks each, plus a reload in RST
    press(8'h52); tk(mk(1'b1, 1'b0, 1'b1, 8'd64, 1'b1));
    tk(mk(1'b1, 1'b0, 1'b1, 8'd64, 1'b0));
    tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0));
    tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0));
    press(8'h52); tk(mk(1'b1, 1'b0, 1'b1, 8'd64, 1'b1));
    tk(mk(1'b1, 1'b0, 1'b1, 8'd64, 1'b0));
    press(8'h52); tk(mk(1'b1, 1'b0, 1'b1, 8'd64, 1'b1));
    tk(mk(1'b1, 1'b0, 1'b1, 8'd64, 1'b0));
    tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0));

    // 3: ten 'U' saturating at 16, then 'N'
    for (int i = 0; i < 10; i++) begin
      press(8'h55);
      tk(mk(1'b1, 1'b0, 1'b0, exp_u[i], 1'b1));
    end
    press(8'h4E); tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b1));

    // 4: folding instance accepts 'e'; unknown 'Z' is silent
    press(8'h44); tk(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b1));
    press(8'h65); tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b1));
    press(8'h5A); tk(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0));
    // 4b: non-folding instance ignores 'Z', 'd', 'e' but obeys 'E'
    nf_en = 1'b1;
    press_nf(8'h5A); tk2(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0), mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    press_nf(8'h64); tk2(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0), mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    press_nf(8'h65); tk2(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0), mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    press_nf(8'h45); tk2(mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b0), mk(1'b1, 1'b0, 1'b0, 8'd64, 1'b1));
    nf_en = 1'b0;

    // 5: last key wins, pending consumed once, bypass on coincident tick
    press(8'h46); press(8'h42);
    tk(mk(1'b0, 1'b0, 1'b0, 8'd64, 1'b1));
    tk(mk(1'b0, 1'b0, 1'b0, 8'd64, 1'b0));
    press_tick(8'h44, mk(1'b0, 1'b1, 1'b0, 8'd64, 1'b1));

    // 'L' saturating at 192, then 'N'
    for (int i = 0; i < 18; i++) begin
      s_exp = (64 + 8 * (i + 1) > 192) ? 8'd192 : 8'(64 + 8 * (i + 1));
      press(8'h4C);
      tk(mk(1'b0, 1'b1, 1'b0, s_exp, 1'b1));
    end
    press(8'h4E); tk(mk(1'b0, 1'b1, 1'b0, 8'd64, 1'b1));

    // 6: reset while in RST with 'L' pending; afterwards a bare tick does nothing
    press(8'h52); tk(mk(1'b0, 1'b1, 1'b1, 8'd64, 1'b1));
    press(8'h4C);
    do_reset();
    tk(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));
    tk(mk(1'b1, 1'b1, 1'b0, 8'd64, 1'b0));

    repeat (3) @(negedge clk);
    n_chk++;
    if (q_m.size() != 0) begin
      n_fail++;
      $display("FAIL main_drain: %0d expectations left, exp 0", q_m.size());
    end
    n_chk++;
    if (q_n.size() != 0) begin
      n_fail++;
      $display("FAIL nf_drain: %0d expectations left, exp 0", q_n.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_music_ctrl_gen.md
Name: kbd_music_ctrl_gen

Overview:
Parametrised keyboard-to-player control block. It takes ASCII key codes from the keyboard decoder and drives the audio player's direction, pause, restart and playback-rate controls. It is fully synchronous to one clock, and music-rate timing arrives as a one-cycle tick enable. It adds per-press one-shot command consumption for every key, a multi-tick restart pulse, saturating tempo control and optional lowercase acceptance.

Parameters:
SPEED_W, 8, width of speed_div output
SPEED_DEFAULT, 8'd64, speed_div value after reset and on 'N'
SPEED_MIN, 8'd16, lower saturation bound (fastest)
SPEED_MAX, 8'd192, upper saturation bound (slowest)
SPEED_STEP, 8'd8, amount added/subtracted per 'L'/'U'
RESTART_TICKS, 2, number of ticks restart stays high (>=1)
CASE_FOLD, 1, 1 = codes 'a'..'z' are treated as 'A'..'Z'

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
tick  in  1  one-clk-wide music-rate enable; commands execute only on tick cycles
kbd_received_ascii_code  in  8  ASCII code from keyboard decoder
update_code  in  1  one-clk strobe: kbd_received_ascii_code holds a new key press
increment  out  1  1 = play forward, 0 = play backward
pause  out  1  1 = playback paused
restart  out  1  1 = player address returns to start
speed_div  out  SPEED_W  playback rate divider; smaller = faster
cmd_done  out  1  one-clk pulse when a recognised command executes

Behaviour:
- All outputs are registered. Reset values: increment=1, pause=1, restart=0, speed_div=SPEED_DEFAULT, cmd_done=0. Pending register and restart counter are cleared on reset.
- Capture: on update_code, the code is case-folded if CASE_FOLD=1 and loaded into an 8-bit pending register, and pending_valid is set. The pending register is one deep; a second update before the next tick overwrites the first, and the last key wins.
- Execution: on a tick cycle, the candidate command is the incoming code if update_code=1 that cycle (bypass), otherwise the pending code if pending_valid=1. The command executes, and pending_valid clears in that same cycle. Outputs change on the clk edge ending that tick cycle, so latency from tick is 1 clk.
- Each key press executes exactly once. With no pending command, a tick leaves control outputs unchanged. Repeated identical presses each execute, because every update_code re-arms execution.
- Key map (uppercase hex):
  - 'E' 45: pause<=0
  - 'D' 44: pause<=1
  - 'F' 46: increment<=1
  - 'B' 42: increment<=0
  - 'R' 52: start restart
  - 'U' 55: speed_div <= max(speed_div-SPEED_STEP, SPEED_MIN)
  - 'L' 4C: speed_div <= min(speed_div+SPEED_STEP, SPEED_MAX)
  - 'N' 4E: speed_div <= SPEED_DEFAULT
- Speed arithmetic: compute in SPEED_W+1 bits so there is no wrap. Underflow or overflow saturates at the bound. Pressing 'U' at SPEED_MIN or 'L' at SPEED_MAX is still a recognised command and still pulses cmd_done.
- Any other code is consumed silently: no output change and no cmd_done.
- cmd_done is high for exactly 1 clk, on the edge where a recognised command takes effect.
- Restart FSM, two states:
  - RUN: restart=0. On an 'R' command, go to RST, set restart=1 and load cnt=RESTART_TICKS-1.
  - RST: restart=1. On each tick with no 'R' command: if cnt==0, go to RUN (restart<=0); otherwise cnt<=cnt-1. An 'R' command while in RST reloads cnt=RESTART_TICKS-1 and stays in RST.
  - With RESTART_TICKS=1, restart stays high from the 'R' tick until the next tick.
- Other commands execute normally while in RST. Pause and direction are independent of restart.
- Reset mid-operation: reset=0 overrides tick and update_code in the same cycle. All state returns to reset values, and any pending command is discarded.

Test Plan:
1. Reset, then update_code with 'E' and a tick 3 clk later -> one clk after the tick, pause=0 and cmd_done pulses once; increment=1 and speed_div=64 are unchanged.
2. 'R' pressed twice (separate update_code strobes, each followed by a tick 4 ticks apart, RESTART_TICKS=2) -> restart is high for 2 ticks after each press; the second 'R' executes even though the code value is unchanged.
3. Ten 'U' presses, each followed by a tick, from speed_div=64 -> 56, 48 ... 16, then 16 for the remaining 4 presses; cmd_done pulses 10 times. Then 'N' -> 64.
4. 'e' with CASE_FOLD=1 -> pause=0. Then 'Z' and 'd' without folding (CASE_FOLD=0 instance) -> no output change and no cmd_done.
5. update_code 'F' then 'B' before any tick -> at the next tick increment=0 ('B' wins) and cmd_done pulses once. update_code 'D' coincident with tick -> pause=1 one clk later (bypass).
6. reset=0 asserted while in RST with a pending 'L' -> next clk restart=0, speed_div=64, pause=1; after release, a tick with no new key produces no change.
